// File: rtl/exu_mdu_if.sv
// Request/writeback bundle between EXU issue logic and the iterative mul/div unit.
// The master side issues ops and may flush; the slave side is the unit itself.
interface exu_mdu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [4:0]      in_rd_addr;
  logic [XLEN-1:0] in_tag;
  logic            flush;
  logic            busy;
  logic            out_valid;
  logic [XLEN-1:0] out_data;
  logic [4:0]      out_rd_addr;
  logic            out_rd_wr_en;
  logic [XLEN-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd_addr, in_tag, flush,
    input  in_ready, busy, out_valid, out_data, out_rd_addr, out_rd_wr_en, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd_addr, in_tag, flush,
    output in_ready, busy, out_valid, out_data, out_rd_addr, out_rd_wr_en, out_tag
  );
endinterface

// File: rtl/exu_mdu.sv
// Iterative RV M-extension unit: radix-2^MUL_BPC shift-add multiplier and restoring
// divider on operand magnitudes, sign fix-up at the end, one-cycle writeback pulse.
//
// state | meaning
// IDLE  | ready for a new op
// CALC  | iterating multiply or divide steps, cnt_q counts down to 0
// FIXUP | apply result sign, select half, register writeback bundle
// DONE  | out_valid high for this single cycle
module exu_mdu #(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 2
) (
  input logic      clk,
  input logic      rst,
  exu_mdu_if.slave mdu
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int PW = XLEN + MUL_BPC;
  localparam logic [CW-1:0]   MUL_CNT = CW'(XLEN / MUL_BPC - 1);
  localparam logic [CW-1:0]   DIV_CNT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t          state_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] hi_q, lo_q, opb_q, tag_q;
  logic [4:0]      rd_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q, fast_q;
  logic            in_ready_q, busy_q, out_valid_q, out_wr_en_q;
  logic [XLEN-1:0] out_data_q, out_tag_q;
  logic [4:0]      out_rd_q;

  logic            accept, in_div, a_sgn, b_sgn, a_neg, b_neg;
  logic            div_zero, div_ovf, res_neg;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  assign accept = mdu.in_valid & in_ready_q & ~mdu.flush;

  always_comb begin
    in_div   = mdu.in_op[2];
    a_sgn    = in_div ? ~mdu.in_op[0] : (mdu.in_op == OP_MULH || mdu.in_op == OP_MULHSU);
    b_sgn    = in_div ? ~mdu.in_op[0] : (mdu.in_op == OP_MULH);
    a_neg    = a_sgn & mdu.in_rs1[XLEN-1];
    b_neg    = b_sgn & mdu.in_rs2[XLEN-1];
    a_mag    = a_neg ? -mdu.in_rs1 : mdu.in_rs1;
    b_mag    = b_neg ? -mdu.in_rs2 : mdu.in_rs2;
    div_zero = in_div & (mdu.in_rs2 == '0);
    div_ovf  = in_div & a_sgn & (mdu.in_rs1 == MIN_NEG) & (mdu.in_rs2 == '1);
    // remainder follows the dividend sign; everything else follows sign mismatch
    res_neg  = (in_div & mdu.in_op[1]) ? a_neg : (a_neg ^ b_neg);
    fast_res = '0;
    if (div_zero)     fast_res = mdu.in_op[1] ? mdu.in_rs1 : '1;
    else if (div_ovf) fast_res = mdu.in_op[1] ? '0 : mdu.in_rs1;
  end

  logic [PW-1:0]     partial, msum;
  logic [XLEN:0]     dshift, ddiff;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   div_raw, result;

  always_comb begin
    partial  = PW'(opb_q) * PW'(lo_q[MUL_BPC-1:0]);
    msum     = {{MUL_BPC{1'b0}}, hi_q} + partial;
    dshift   = {hi_q, lo_q[XLEN-1]};
    ddiff    = dshift - {1'b0, opb_q};
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    div_raw  = op_q[1] ? hi_q : lo_q;
    if (fast_q)               result = lo_q;
    else if (op_q[2])         result = neg_q ? -div_raw : div_raw;
    else if (op_q == OP_MUL)  result = prod_fix[XLEN-1:0];
    else                      result = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
      tag_q       <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      fast_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_wr_en_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_rd_q    <= '0;
    end else if (mdu.flush) begin
      // writeback registers keep the last completed result
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_wr_en_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            op_q       <= mdu.in_op;
            rd_q       <= mdu.in_rd_addr;
            tag_q      <= mdu.in_tag;
            neg_q      <= res_neg;
            fast_q     <= div_zero | div_ovf;
            hi_q       <= '0;
            lo_q       <= (div_zero | div_ovf) ? fast_res : (in_div ? a_mag : b_mag);
            opb_q      <= in_div ? b_mag : a_mag;
            cnt_q      <= in_div ? DIV_CNT : MUL_CNT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= (div_zero | div_ovf) ? S_FIXUP : S_CALC;
          end
        end
        S_CALC: begin
          if (op_q[2]) begin
            hi_q <= ddiff[XLEN] ? dshift[XLEN-1:0] : ddiff[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], ~ddiff[XLEN]};
          end else begin
            hi_q <= msum[PW-1:MUL_BPC];
            lo_q <= {msum[MUL_BPC-1:0], lo_q[XLEN-1:MUL_BPC]};
          end
          if (cnt_q == '0) state_q <= S_FIXUP;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        S_FIXUP: begin
          out_data_q  <= result;
          out_rd_q    <= rd_q;
          out_tag_q   <= tag_q;
          out_wr_en_q <= (rd_q != 5'd0);
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          out_valid_q <= 1'b0;
          out_wr_en_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mdu.in_ready     = in_ready_q;
  assign mdu.busy         = busy_q;
  assign mdu.out_valid    = out_valid_q;
  assign mdu.out_data     = out_data_q;
  assign mdu.out_rd_addr  = out_rd_q;
  assign mdu.out_rd_wr_en = out_wr_en_q;
  assign mdu.out_tag      = out_tag_q;

endmodule

// File: tb/tb_exu_mdu.sv
// Scoreboard bench for exu_mdu: directed ops on the 32/2 build, plus a
// reference-model sweep on 64/4 and 32/1 builds.
module tb_exu_mdu;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic [63:0] tag;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q0[$];
  exp_t q64[$];
  exp_t q1[$];
  exp_t e0, e64, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exu_mdu_if #(.XLEN(32)) m0 ();
  exu_mdu_if #(.XLEN(64)) m64 ();
  exu_mdu_if #(.XLEN(32)) m1 ();

  exu_mdu #(.XLEN(32), .MUL_BPC(2)) dut   (.clk(clk), .rst(rst), .mdu(m0));
  exu_mdu #(.XLEN(64), .MUL_BPC(4)) dut64 (.clk(clk), .rst(rst), .mdu(m64));
  exu_mdu #(.XLEN(32), .MUL_BPC(1)) dut1  (.clk(clk), .rst(rst), .mdu(m1));

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, expv);
    end
  endtask

  task automatic check_pop(input string who, input exp_t e, input logic [63:0] data,
                           input logic [4:0] rd, input logic wr, input logic [63:0] tag,
                           input int lat);
    cmp({who, " data"}, data, e.data);
    cmp({who, " rd"}, 64'(rd), 64'(e.rd));
    cmp({who, " wr_en"}, 64'(wr), 64'(e.rd != 5'd0));
    cmp({who, " tag"}, tag, e.tag);
    cmp({who, " latency"}, 64'(lat), 64'(e.lat));
  endtask

  // independent arithmetic model on sign-extended 128-bit values
  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input int xl);
    logic [63:0]        mask, ua, ub, mn, r;
    logic [127:0]       sa, sb, p;
    logic signed [63:0] qa, qb;
    mask = (xl == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
    mn   = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    ua   = a & mask;
    ub   = b & mask;
    sa   = (xl == 64) ? {{64{a[63]}}, a} : {{96{a[31]}}, a[31:0]};
    sb   = (xl == 64) ? {{64{b[63]}}, b} : {{96{b[31]}}, b[31:0]};
    qa   = sa[63:0];
    qb   = sb[63:0];
    r    = '0;
    p    = '0;
    case (op)
      3'd0: begin p = {64'b0, ua} * {64'b0, ub}; r = p[63:0]; end
      3'd1: begin p = (sa * sb) >> xl; r = p[63:0]; end
      3'd2: begin p = (sa * {64'b0, ub}) >> xl; r = p[63:0]; end
      3'd3: begin p = ({64'b0, ua} * {64'b0, ub}) >> xl; r = p[63:0]; end
      3'd4: r = (ub == 0) ? mask : (ua == mn && ub == mask) ? ua : 64'(qa / qb);
      3'd5: r = (ub == 0) ? mask : ua / ub;
      3'd6: r = (ub == 0) ? ua : (ua == mn && ub == mask) ? 64'd0 : 64'(qa % qb);
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return r & mask;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input int xl, input int bpc);
    logic [63:0] mask, mn;
    mask = (xl == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
    mn   = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    if (!op[2]) return xl / bpc + 2;
    if ((b & mask) == 0) return 2;
    if (!op[0] && (a & mask) == mn && (b & mask) == mask) return 2;
    return xl + 2;
  endfunction

  // monitors: pop one expectation per out_valid pulse
  always @(negedge clk) begin
    if (m0.out_valid) begin
      cmp("d32 in_ready during DONE", 64'(m0.in_ready), 64'd0);
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL d32 unexpected out_valid: got data=%0h expected no output", m0.out_data);
      end else begin
        e0 = q0.pop_front();
        check_pop("d32", e0, 64'(m0.out_data), m0.out_rd_addr, m0.out_rd_wr_en,
                  64'(m0.out_tag), cyc - e0.acc);
      end
    end
  end

  always @(negedge clk) begin
    if (m64.out_valid) begin
      if (q64.size() == 0) begin
        checks++; errors++;
        $display("FAIL d64 unexpected out_valid: got data=%0h expected no output", m64.out_data);
      end else begin
        e64 = q64.pop_front();
        check_pop("d64", e64, m64.out_data, m64.out_rd_addr, m64.out_rd_wr_en,
                  m64.out_tag, cyc - e64.acc);
      end
    end
  end

  always @(negedge clk) begin
    if (m1.out_valid) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d32b1 unexpected out_valid: got data=%0h expected no output", m1.out_data);
      end else begin
        e1 = q1.pop_front();
        check_pop("d32b1", e1, 64'(m1.out_data), m1.out_rd_addr, m1.out_rd_wr_en,
                  64'(m1.out_tag), cyc - e1.acc);
      end
    end
  end

  // drive an op and leave in_valid high; returns at the accepting edge
  task automatic issue0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] tag, input logic [31:0] expd,
                        input int lat, input bit push, output int acc);
    int n;
    @(negedge clk);
    m0.in_op = op; m0.in_rs1 = a; m0.in_rs2 = b;
    m0.in_rd_addr = rd; m0.in_tag = tag; m0.in_valid = 1'b1;
    n = 0;
    while (!m0.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!m0.in_ready) begin
      checks++; errors++;
      $display("FAIL d32 accept timeout: in_ready=0 after %0d cycles, required 1", n);
    end
    acc = cyc;
    if (push) q0.push_back('{64'(expd), rd, 64'(tag), lat, acc});
    @(posedge clk);
  endtask

  task automatic idle0();
    @(negedge clk);
    m0.in_valid = 1'b0;
  endtask

  task automatic drain(input string who);
    int n;
    n = 0;
    while ((q0.size() + q64.size() + q1.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if ((q0.size() + q64.size() + q1.size()) != 0) begin
      checks++; errors++;
      $display("FAIL %s drain timeout: %0d results outstanding, required 0", who,
               q0.size() + q64.size() + q1.size());
      q0.delete(); q64.delete(); q1.delete();
    end
    @(negedge clk);
  endtask

  logic [2:0]  av_op [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd4, 3'd6};
  logic [63:0] av_a  [10] = '{64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0000,
                              64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_8000_0000,
                              64'hFFFF_FFFF_FFFF_FF9C, 64'h1234_5678_9ABC_DEF0,
                              64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
  logic [63:0] av_b  [10] = '{64'hFEDC_BA98_7654_3210, 64'h7FFF_FFFF_FFFF_FFFF,
                              64'hFFFF_FFFF_0000_0007, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'h0000_0000_0000_0007, 64'h0000_0000_0000_0003,
                              64'h0000_0000_0000_0007, 64'h0000_0000_0000_03E8,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000};

  initial begin
    #500000;
    $display("FAIL global timeout: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int a, b;
    m0.in_valid = 0; m0.flush = 0; m0.in_op = 0; m0.in_rs1 = 0; m0.in_rs2 = 0;
    m0.in_rd_addr = 0; m0.in_tag = 0;
    m64.in_valid = 0; m64.flush = 0; m64.in_op = 0; m64.in_rs1 = 0; m64.in_rs2 = 0;
    m64.in_rd_addr = 0; m64.in_tag = 0;
    m1.in_valid = 0; m1.flush = 0; m1.in_op = 0; m1.in_rs1 = 0; m1.in_rs2 = 0;
    m1.in_rd_addr = 0; m1.in_tag = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    cmp("reset out_valid", 64'(m0.out_valid), 64'd0);
    cmp("reset out_data", 64'(m0.out_data), 64'd0);
    cmp("reset out_tag", 64'(m0.out_tag), 64'd0);
    cmp("reset busy", 64'(m0.busy), 64'd0);
    cmp("reset in_ready held", 64'(m0.in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    cmp("in_ready after reset", 64'(m0.in_ready), 64'd1);

    issue0(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'h1000, 32'hFFFF_FFEB, 18, 1, a);
    idle0();
    drain("mul");

    // in_valid held high across three multiplies
    issue0(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h1004, 32'hFFFF_FFFE, 18, 1, a);
    issue0(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h1008, 32'h0000_0000, 18, 1, b);
    cmp("mul back-to-back accept gap", 64'(b - a), 64'd19);
    issue0(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h100C, 32'hFFFF_FFFF, 18, 1, a);
    idle0();
    drain("mulh");

    issue0(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'h1010, 32'hFFFF_FFFD, 34, 1, a);
    issue0(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'h1014, 32'hFFFF_FFFF, 34, 1, b);
    cmp("div back-to-back accept gap", 64'(b - a), 64'd35);
    idle0();
    drain("div");

    issue0(3'd5, 32'd5, 32'd0, 5'd10, 32'h1018, 32'hFFFF_FFFF, 2, 1, a);
    issue0(3'd7, 32'd5, 32'd0, 5'd10, 32'h101C, 32'd5, 2, 1, b);
    cmp("fast path accept gap", 64'(b - a), 64'd3);
    issue0(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h1020, 32'h8000_0000, 2, 1, a);
    issue0(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h1024, 32'h0000_0000, 2, 1, a);
    issue0(3'd4, 32'd5, 32'd0, 5'd10, 32'h1028, 32'hFFFF_FFFF, 2, 1, a);
    issue0(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd10, 32'h102C, 32'hFFFF_FFF9, 2, 1, a);
    idle0();
    drain("fast");

    // flush a divide in its tenth CALC cycle
    issue0(3'd4, 32'd100, 32'd7, 5'd13, 32'h2000, 32'd0, 34, 0, a);
    idle0();
    while (cyc < a + 10) @(negedge clk);
    m0.flush = 1'b1;
    @(negedge clk);
    m0.flush = 1'b0;
    cmp("flush busy", 64'(m0.busy), 64'd0);
    cmp("flush in_ready", 64'(m0.in_ready), 64'd1);
    cmp("flush out_valid", 64'(m0.out_valid), 64'd0);
    issue0(3'd0, 32'd6, 32'd7, 5'd11, 32'h2004, 32'd42, 18, 1, a);
    idle0();
    drain("after flush");
    repeat (20) @(negedge clk);

    // in_valid together with flush must not start an op
    m0.in_op = 3'd0; m0.in_rs1 = 32'd3; m0.in_rs2 = 32'd3; m0.in_rd_addr = 5'd1;
    m0.in_valid = 1'b1; m0.flush = 1'b1;
    @(negedge clk);
    m0.in_valid = 1'b0; m0.flush = 1'b0;
    cmp("flush+valid busy", 64'(m0.busy), 64'd0);
    repeat (25) @(negedge clk);

    // reset mid-CALC clears the writeback bundle
    issue0(3'd0, 32'd9, 32'd9, 5'd14, 32'h3000, 32'd0, 18, 0, a);
    idle0();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp("rst mid-op out_data", 64'(m0.out_data), 64'd0);
    cmp("rst mid-op out_tag", 64'(m0.out_tag), 64'd0);
    cmp("rst mid-op out_rd_addr", 64'(m0.out_rd_addr), 64'd0);
    cmp("rst mid-op out_valid", 64'(m0.out_valid), 64'd0);
    cmp("rst mid-op busy", 64'(m0.busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    cmp("rst mid-op in_ready", 64'(m0.in_ready), 64'd1);
    repeat (25) @(negedge clk);
    issue0(3'd5, 32'd100, 32'd7, 5'd12, 32'h3004, 32'd14, 34, 1, a);
    idle0();
    drain("after rst");

    // XLEN=64/MUL_BPC=4 and XLEN=32/MUL_BPC=1 against the model
    for (int i = 0; i < 10; i++) begin
      int n;
      @(negedge clk);
      m64.in_op = av_op[i]; m64.in_rs1 = av_a[i]; m64.in_rs2 = av_b[i];
      m64.in_rd_addr = 5'(i); m64.in_tag = 64'hA000 + 64'(i); m64.in_valid = 1'b1;
      m1.in_op = av_op[i]; m1.in_rs1 = av_a[i][31:0]; m1.in_rs2 = av_b[i][31:0];
      m1.in_rd_addr = 5'(i); m1.in_tag = 32'hB000 + 32'(i); m1.in_valid = 1'b1;
      n = 0;
      while (!(m64.in_ready && m1.in_ready) && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!(m64.in_ready && m1.in_ready)) begin
        checks++; errors++;
        $display("FAIL sweep accept timeout: ready64=%0d ready1=%0d, required 1", m64.in_ready, m1.in_ready);
      end
      q64.push_back('{model(av_op[i], av_a[i], av_b[i], 64), 5'(i), 64'hA000 + 64'(i),
                      exp_lat(av_op[i], av_a[i], av_b[i], 64, 4), cyc});
      q1.push_back('{model(av_op[i], av_a[i], av_b[i], 32), 5'(i), 64'hB000 + 64'(i),
                     exp_lat(av_op[i], av_a[i], av_b[i], 32, 1), cyc});
      @(posedge clk);
      @(negedge clk);
      m64.in_valid = 1'b0;
      m1.in_valid = 1'b0;
      drain("sweep");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
